// File: rtl/bb_psum_drain_pkg.sv
// bb_psum_drain_pkg: shared sizing constants and FSM encoding for the partial-sum drain
package bb_psum_drain_pkg;
   localparam int DEF_N_PSUM     = 16;
   localparam int DEF_BITS_PSUM  = 20;
   localparam int DEF_BITS_OUT   = 8;
   localparam int DEF_BITS_SHIFT = 5;
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;
endpackage

// File: rtl/bb_requant.sv
// bb_requant: rounding arithmetic right shift, optional ReLU and signed saturation
module bb_requant
   import bb_psum_drain_pkg::*;
#(
   parameter int BITS_PSUM  = DEF_BITS_PSUM,
   parameter int BITS_OUT   = DEF_BITS_OUT,
   parameter int BITS_SHIFT = DEF_BITS_SHIFT
) (
   input  logic [BITS_PSUM-1:0]  x,
   input  logic [BITS_SHIFT-1:0] shift,
   input  logic                  relu,
   output logic [BITS_OUT-1:0]   y
);
   localparam logic [BITS_SHIFT-1:0] S_MAX = BITS_SHIFT'(BITS_PSUM - 1);
   logic [BITS_SHIFT-1:0] s;
   logic signed [BITS_PSUM:0] xe, rnd, sum, sh, r;
   logic hi, lo;
   // one extra bit of headroom so the rounding add can never wrap
   always_comb begin
      s   = (shift > S_MAX) ? S_MAX : shift;
      xe  = {x[BITS_PSUM-1], x};
      rnd = (s == '0) ? '0 : (BITS_PSUM+1)'(1) << (s - 1'b1);
      sum = xe + rnd;
      sh  = sum >>> s;
      r   = (relu & sh[BITS_PSUM]) ? '0 : sh;
      hi  = !r[BITS_PSUM] & (|r[BITS_PSUM-1:BITS_OUT-1]);
      lo  = r[BITS_PSUM] & !(&r[BITS_PSUM-1:BITS_OUT-1]);
      y   = hi ? {1'b0, {(BITS_OUT-1){1'b1}}} :
            lo ? {1'b1, {(BITS_OUT-1){1'b0}}} : r[BITS_OUT-1:0];
   end
endmodule

// File: rtl/bb_psum_drain.sv
// bb_psum_drain: ping-pong capture of core partial sums, requantized and streamed one word per beat
module bb_psum_drain
   import bb_psum_drain_pkg::*;
#(
   parameter int N_PSUM     = DEF_N_PSUM,
   parameter int BITS_PSUM  = DEF_BITS_PSUM,
   parameter int BITS_OUT   = DEF_BITS_OUT,
   parameter int BITS_SHIFT = DEF_BITS_SHIFT
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        i_Done,
   input  logic [N_PSUM*BITS_PSUM-1:0] i_Psum,
   input  logic [BITS_SHIFT-1:0]       i_Shift,
   input  logic                        i_Relu,
   output logic                        o_Valid,
   input  logic                        i_Ready,
   output logic [BITS_OUT-1:0]         o_Data,
   output logic [3:0]                  o_Index,
   output logic                        o_Last,
   output logic                        o_Full,
   output logic                        o_Overrun
);
   logic [BITS_PSUM-1:0]  bank [2][N_PSUM];
   logic [BITS_SHIFT-1:0] shift_q [2];
   logic [1:0] relu_q, full, full_n;
   logic wp, rp, wp_n, rp_n, valid, beat, last_beat, cap_ok, overrun;
   logic [0:0] state, state_n;
   logic [3:0] idx, idx_n;
   logic [BITS_OUT-1:0] q;
   // a final beat frees its bank before a same-edge capture looks for room
   always_comb begin
      valid     = state == ST_DRAIN;
      beat      = valid & i_Ready;
      last_beat = beat & (idx == 4'(N_PSUM - 1));
      cap_ok    = i_Done & (!full[wp] | (last_beat & (rp == wp)));
      full_n    = full;
      if (last_beat) full_n[rp] = 1'b0;
      if (cap_ok) full_n[wp] = 1'b1;
      rp_n      = rp ^ last_beat;
      wp_n      = wp ^ cap_ok;
      state_n   = full_n[rp_n] ? ST_DRAIN : ST_IDLE;
      idx_n     = (last_beat | !valid) ? '0 : idx + {3'b0, beat};
   end
   always_ff @(posedge CLK) begin
      if (!RST) begin
         full    <= '0;
         wp      <= 1'b0;
         rp      <= 1'b0;
         state   <= ST_IDLE;
         idx     <= '0;
         overrun <= 1'b0;
      end else begin
         full    <= full_n;
         wp      <= wp_n;
         rp      <= rp_n;
         state   <= state_n;
         idx     <= idx_n;
         overrun <= overrun | (i_Done & !cap_ok);
      end
   end
   always_ff @(posedge CLK) begin
      if (cap_ok) begin
         for (int k = 0; k < N_PSUM; k++) bank[wp][k] <= i_Psum[BITS_PSUM*k +: BITS_PSUM];
         shift_q[wp] <= i_Shift;
         relu_q[wp]  <= i_Relu;
      end
   end
   bb_requant #(.BITS_PSUM(BITS_PSUM), .BITS_OUT(BITS_OUT), .BITS_SHIFT(BITS_SHIFT)) u_requant (
      .x(bank[rp][idx]),
      .shift(shift_q[rp]),
      .relu(relu_q[rp]),
      .y(q)
   );
   assign o_Valid   = valid;
   assign o_Data    = valid ? q : '0;
   assign o_Index   = idx;
   assign o_Last    = valid & (idx == 4'(N_PSUM - 1));
   assign o_Full    = &full;
   assign o_Overrun = overrun;
endmodule

// File: tb/tb_bb_psum_drain.sv
// tb_bb_psum_drain: directed self-checking bench for the partial-sum drain
module tb_bb_psum_drain;
   localparam int N = 16;
   localparam int PB = 20;
   logic CLK, RST, i_Done, i_Relu, i_Ready;
   logic [N*PB-1:0] i_Psum, pend_psum;
   logic [4:0] i_Shift, pend_shift;
   logic o_Valid, o_Last, o_Full, o_Overrun;
   logic [7:0] o_Data;
   logic [3:0] o_Index;
   int n_chk = 0, n_fail = 0;
   int va[N], vb[N], vc[N], ea[N], eb[N], ec[N];

   bb_psum_drain dut (
      .CLK(CLK), .RST(RST), .i_Done(i_Done), .i_Psum(i_Psum), .i_Shift(i_Shift),
      .i_Relu(i_Relu), .o_Valid(o_Valid), .i_Ready(i_Ready), .o_Data(o_Data),
      .o_Index(o_Index), .o_Last(o_Last), .o_Full(o_Full), .o_Overrun(o_Overrun)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [N*PB-1:0] pack(input int v[N]);
      logic [N*PB-1:0] p;
      for (int k = 0; k < N; k++) p[k*PB +: PB] = PB'(v[k]);
      return p;
   endfunction

   task automatic issue(input int v[N], input int sh, input logic rl);
      i_Psum = pack(v);
      i_Shift = 5'(sh);
      i_Relu = rl;
      i_Done = 1'b1;
      tick();
      i_Done = 1'b0;
   endtask

   // drains one tile at full rate; optionally pulses i_Done with pend_psum at beat done_at
   task automatic drain(input string tag, input int e[N], input int done_at);
      i_Ready = 1'b1;
      for (int k = 0; k < N; k++) begin
         chk({tag, "_valid"}, int'(o_Valid), 1);
         chk({tag, "_index"}, int'(o_Index), k);
         chk({tag, "_data"}, int'($signed(o_Data)), e[k]);
         chk({tag, "_last"}, int'(o_Last), int'(k == N - 1));
         if (k == done_at) begin
            i_Psum = pend_psum;
            i_Shift = pend_shift;
            i_Relu = 1'b0;
            i_Done = 1'b1;
         end
         tick();
         i_Done = 1'b0;
      end
   endtask

   initial begin
      RST = 1'b0; i_Done = 1'b0; i_Psum = '0; i_Shift = '0; i_Relu = 1'b0; i_Ready = 1'b0;
      pend_psum = '0; pend_shift = '0;
      tick();
      tick();
      chk("rst_valid", int'(o_Valid), 0);
      chk("rst_data", int'(o_Data), 0);
      chk("rst_index", int'(o_Index), 0);
      chk("rst_last", int'(o_Last), 0);
      chk("rst_full", int'(o_Full), 0);
      chk("rst_overrun", int'(o_Overrun), 0);
      RST = 1'b1;
      tick();

      // basic drain with saturation
      for (int k = 0; k < N; k++) begin va[k] = k * 100; ea[k] = (k * 100 > 127) ? 127 : k * 100; end
      i_Ready = 1'b1;
      issue(va, 0, 1'b0);
      drain("basic", ea, -1);
      chk("basic_idle", int'(o_Valid), 0);

      // rounding, sign, saturation low, then ReLU on the same values
      for (int k = 0; k < N; k++) begin va[k] = 0; ea[k] = 0; eb[k] = 0; end
      va[0] = 5; va[1] = -5; va[2] = 6; va[3] = -6; va[4] = -1000;
      ea[0] = 3; ea[1] = -2; ea[2] = 3; ea[3] = -3; ea[4] = -128;
      eb[0] = 3; eb[2] = 3;
      issue(va, 1, 1'b0);
      drain("round", ea, -1);
      issue(va, 1, 1'b1);
      drain("relu", eb, -1);

      // oversize shift clamps to 19, rounding add must not wrap
      for (int k = 0; k < N; k++) begin va[k] = 0; ea[k] = 0; end
      va[0] = 524287; va[1] = -524288; ea[0] = 1; ea[1] = -1;
      issue(va, 31, 1'b0);
      drain("clamp", ea, -1);

      // backpressure with ready pattern 1,0,0,1,0,0,...
      for (int k = 0; k < N; k++) va[k] = k * 3;
      i_Ready = 1'b0;
      issue(va, 0, 1'b0);
      begin
         int cnt = 0;
         for (int c = 0; c < 100 && cnt < N; c++) begin
            i_Ready = (c % 3 == 0);
            chk("bp_valid", int'(o_Valid), 1);
            chk("bp_index", int'(o_Index), cnt);
            chk("bp_data", int'($signed(o_Data)), cnt * 3);
            if (i_Ready) cnt++;
            tick();
         end
         chk("bp_count", cnt, N);
      end
      chk("bp_idle", int'(o_Valid), 0);

      // ping-pong: second tile arrives mid-drain with its own shift
      for (int k = 0; k < N; k++) begin
         va[k] = 4 * k + 1; ea[k] = 4 * k + 1; vb[k] = 10 * k; eb[k] = 5 * k;
      end
      pend_psum = pack(vb); pend_shift = 5'd1;
      i_Ready = 1'b1;
      issue(va, 0, 1'b0);
      drain("pp_a", ea, 5);
      drain("pp_b", eb, -1);
      chk("pp_overrun", int'(o_Overrun), 0);
      chk("pp_idle", int'(o_Valid), 0);

      // capture on the final beat while both banks are full is accepted
      for (int k = 0; k < N; k++) begin
         va[k] = k + 1; ea[k] = k + 1; vb[k] = k + 50; eb[k] = k + 50; vc[k] = k + 20; ec[k] = k + 20;
      end
      i_Ready = 1'b0;
      issue(va, 0, 1'b0);
      issue(vb, 0, 1'b0);
      chk("sim_full", int'(o_Full), 1);
      pend_psum = pack(vc); pend_shift = 5'd0;
      drain("sim_a", ea, 15);
      chk("sim_overrun", int'(o_Overrun), 0);
      chk("sim_full2", int'(o_Full), 1);
      drain("sim_b", eb, -1);
      drain("sim_c", ec, -1);
      chk("sim_idle", int'(o_Valid), 0);

      // overrun: third pulse into two full banks is dropped
      for (int k = 0; k < N; k++) vc[k] = 99;
      i_Ready = 1'b0;
      issue(va, 0, 1'b0);
      chk("ovr_full1", int'(o_Full), 0);
      issue(vb, 0, 1'b0);
      chk("ovr_full2", int'(o_Full), 1);
      chk("ovr_flag0", int'(o_Overrun), 0);
      issue(vc, 0, 1'b0);
      chk("ovr_flag1", int'(o_Overrun), 1);
      chk("ovr_full3", int'(o_Full), 1);
      drain("ovr_a", ea, -1);
      drain("ovr_b", eb, -1);
      chk("ovr_idle", int'(o_Valid), 0);
      chk("ovr_sticky", int'(o_Overrun), 1);

      // reset in the middle of a drain
      issue(va, 0, 1'b0);
      i_Ready = 1'b1;
      for (int k = 0; k < 7; k++) tick();
      chk("mid_index", int'(o_Index), 7);
      RST = 1'b0;
      tick();
      RST = 1'b1;
      chk("mid_valid", int'(o_Valid), 0);
      chk("mid_full", int'(o_Full), 0);
      chk("mid_overrun", int'(o_Overrun), 0);
      chk("mid_index0", int'(o_Index), 0);
      chk("mid_data", int'(o_Data), 0);
      for (int k = 0; k < N; k++) begin vb[k] = k + 30; eb[k] = k + 30; end
      issue(vb, 0, 1'b0);
      drain("post", eb, -1);
      chk("post_idle", int'(o_Valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/bb_psum_drain.md
Name: bb_psum_drain

Overview:
- Receiving end of the BitBlade core's partial-sum output interface.
- Captures the 16 packed partial sums on each completion pulse into a two-bank ping-pong buffer.
- Requantizes each sum: rounding arithmetic shift, optional ReLU, signed saturation.
- Streams the results one word per beat over a valid/ready interface to the output SRAM writer, with backpressure to the tile controller.

Parameters:
- N_PSUM, 16, number of partial sums per completion (PE arrays in the core)
- BITS_PSUM, 20, width of one signed partial sum
- BITS_OUT, 8, width of one signed requantized output word
- BITS_SHIFT, 5, width of the shift-amount field

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset, synchronous, active-low
- i_Done  in  1  single-cycle completion pulse from the core
- i_Psum  in  N_PSUM*BITS_PSUM  packed signed sums; entry k is at bits [BITS_PSUM*k +: BITS_PSUM]
- i_Shift  in  BITS_SHIFT  right-shift amount, sampled with i_Done
- i_Relu  in  1  ReLU enable, sampled with i_Done
- o_Valid  out  1  output word valid
- i_Ready  in  1  downstream accepts the word
- o_Data  out  BITS_OUT  requantized signed word
- o_Index  out  4  entry index k of o_Data
- o_Last  out  1  high with entry N_PSUM-1
- o_Full  out  1  both banks occupied; the controller must not issue i_Done
- o_Overrun  out  1  sticky error flag

Behaviour:
- Reset (RST=0 at an edge), applied regardless of any operation in progress:
  - both banks marked empty; FSM to IDLE; index cleared; o_Overrun cleared
  - all outputs 0
  - a drain interrupted by reset is discarded
- Banks:
  - two banks; each holds N_PSUM sums plus the latched shift and relu values
  - a write pointer selects the capture bank and a read pointer selects the drain bank; each pointer toggles on use
- Capture, when i_Done=1 at an edge:
  - a free bank is available: write i_Psum, i_Shift and i_Relu into it and mark it full.
  - both banks are full: drop the data, set o_Overrun (sticky until reset) and leave the bank state unchanged.
- FSM, IDLE state:
  - if the read bank is full, go to DRAIN with index=0.
  - a bank captured at edge t gives o_Valid=1 in cycle t+1 when the FSM was idle.
- FSM, DRAIN state:
  - o_Valid=1.
  - o_Data is the requantized entry [index] of the read bank. o_Data is a combinational function of registered state only, so it is stable while o_Valid=1 and i_Ready=0.
  - A beat completes when o_Valid and i_Ready are both high at an edge. On a completed beat, index increments.
  - On the beat at index N_PSUM-1:
    - free the read bank and toggle the read pointer.
    - if the other bank is full, stay in DRAIN with index=0, so there is no bubble between tiles.
    - otherwise go to IDLE.
- o_Full: combinational; high when both banks are full.
- Simultaneous capture and final beat at the same edge:
  - the freeing happens first, so capture succeeds even if o_Full was high in that cycle.
  - no overrun is flagged.
- Requantization of signed x with s = latched shift:
  - if s=0, y=x.
  - otherwise y = (x + 2^(s-1)) >>> s, with the addition done at BITS_PSUM+1 bits (round half up, no wrap).
  - s values of BITS_PSUM or more are clamped to BITS_PSUM-1.
  - ReLU (if latched relu=1): y<0 gives y=0.
  - Saturate to [-2^(BITS_OUT-1), 2^(BITS_OUT-1)-1].
- o_Index = index; o_Last = (index == N_PSUM-1) & o_Valid.

Decomposition:
- Shared package: N_PSUM, BITS_PSUM, BITS_OUT and BITS_SHIFT defaults, and the FSM state encoding (IDLE, DRAIN). These match the core's BITS_PSUM and PE_ARRAY constants.
- One natural sub-module: bb_requant, purely combinational, implementing shift, round, ReLU and saturate. It is reused by the future activation writer.

Test Plan:
- Basic drain: i_Psum entries k*100 (k=0..15), shift=0, relu=0, i_Ready=1 -> 16 consecutive beats starting the cycle after i_Done; outputs 0, 100, then saturation to 127 from entry 2 onward; o_Last on beat 16; then IDLE.
- Rounding and sign: entry values 5, -5, 6, -6 with shift=1 -> 3, -2, 3, -3. Entry -1000 with relu=1 -> 0. Entry -1000 with relu=0 -> -128.
- Backpressure: i_Ready toggles 1,0,0,1,... -> o_Data and o_Index held while stalled; exactly 16 accepted beats in order 0..15.
- Ping-pong: second i_Done at beat 5 of the first drain, with a different shift -> second bank drains immediately after the first o_Last with no bubble, each bank using its own latched shift; o_Overrun stays 0.
- Overrun: i_Ready=0 and three i_Done pulses -> o_Full=1 after the second; third sets o_Overrun=1; the first two tiles then drain intact. Also: i_Done on the same edge as the final beat with both banks full -> accepted, no overrun.
- Reset mid-drain: RST=0 at beat 7 -> next cycle o_Valid=0, o_Full=0, o_Overrun=0. A new i_Done then gives a drain starting at index 0.
